// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_mem_pkg
// Description : Shared encodings for the MIPS load/store (memory access)
//               stage. It holds the access-size codes, the FSM state
//               encoding, the full byte-enable constant, and a helper that
//               classifies an address/size pair as misaligned.
// Revision    : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

  // Access size, taken from the instruction's mem_size field
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // The reserved size code is treated as a misaligned access, so that it
  // never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Purely combinational byte-lane steering for the load/store
//               stage. The store path produces byte enables and
//               lane-replicated write data. The load path picks the
//               addressed lane out of a little-endian bus word and sign- or
//               zero-extends it to 32 bits.
// Ports       : st_size, st_off, st_wdata -> st_be, st_data   (store path)
//               ld_size, ld_unsigned, ld_off, ld_rdata -> ld_data (load path)
// Revision    : 1.0  initial release
// ============================================================================
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Store path. Narrow data is replicated across lanes, so the memory only
  // needs the byte enables to pick the right bytes.
  always_comb begin
    st_be   = 4'b0000;
    st_data = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_be   = BE_ALL;
        st_data = st_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = st_wdata;
      end
    endcase
  end

  // Load path
  always_comb begin
    byte_lane = ld_rdata[7:0];
    case (ld_off)
      2'd0:    byte_lane = ld_rdata[7:0];
      2'd1:    byte_lane = ld_rdata[15:8];
      2'd2:    byte_lane = ld_rdata[23:16];
      default: byte_lane = ld_rdata[31:24];
    endcase
    half_lane = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_data = 32'd0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: ld_data = {{16{~ld_unsigned & half_lane[15]}}, half_lane};
      SZ_WORD: ld_data = ld_rdata;   // sign mode is irrelevant for words
      default: ld_data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MIPS load/store stage. It takes the ALU result as the
//               effective address and rt as the store data. Each legal
//               access runs on a req/ack data bus of variable latency, and
//               the core is stalled until the access completes. Load
//               results are lane-aligned and extended before write-back.
// Ports       : clk, rst (sync, active-high)
//               core side : mem_read, mem_write, mem_size, load_unsigned,
//                           addr, wdata -> rdata_out, stall, misalign, bus_err
//               bus side  : bus_req, bus_we, bus_addr, bus_be, bus_wdata,
//                           bus_rdata, bus_ack
// Config      : define MEM_TIMEOUT_EN to abort a bus access that gets no
//               ack within TIMEOUT_CYCLES cycles. An abort pulses bus_err.
//               Without this macro, the stage waits for an ack with no
//               limit and bus_err is constant 0.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata_out,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  state_t      state;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;

  logic        access;
  logic        bad_addr;
  logic        legal;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign access   = mem_read | mem_write;
  assign bad_addr = is_misaligned(mem_size, addr[1:0]);
  assign legal    = access & ~bad_addr;
  assign misalign = access & bad_addr;

  // The stall is raised in the IDLE cycle itself. This keeps the PC from
  // advancing before the access has been captured.
  assign stall = ((state == ST_IDLE) && legal) || (state == ST_BUS);

  // The store path works on the live instruction, because it is captured
  // on entry to BUS. The load path works on the captured attributes,
  // because the data arrives several cycles later.
  mem_lane_align u_align (
    .st_size     (mem_size),
    .st_off      (addr[1:0]),
    .st_wdata    (wdata),
    .st_be       (st_be),
    .st_data     (st_data),
    .ld_size     (lat_size),
    .ld_unsigned (lat_unsigned),
    .ld_off      (lat_off),
    .ld_rdata    (bus_rdata),
    .ld_data     (ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign bus_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rdata_out    <= 32'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= 4'b0000;
      bus_wdata    <= 32'd0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      wait_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (legal) begin
            bus_req      <= 1'b1;
            bus_we       <= mem_write;   // a write wins over a read
            bus_addr     <= {addr[ADDR_W-1:2], 2'b00};
            bus_be       <= st_be;
            bus_wdata    <= st_data;
            lat_size     <= mem_size;
            lat_unsigned <= load_unsigned;
            lat_off      <= addr[1:0];
`ifdef MEM_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
            state        <= ST_BUS;
          end
        end
        ST_BUS: begin
          // An ack takes priority, even in the cycle where the limit is hit
          if (bus_ack) begin
            if (!bus_we) begin
              rdata_out <= ld_data;
            end
            bus_req <= 1'b0;
            state   <= ST_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            bus_req <= 1'b0;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          // The core retires the instruction here, so never re-issue it
          state <= ST_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Each transaction
//               is described by its spec-level timeline: one IDLE stall
//               cycle, N bus cycles, then a DONE cycle. A negedge compare
//               process checks every output against that timeline. Literal
//               checks pin the key results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_out;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .load_unsigned(load_unsigned), .addr(addr),
    .wdata(wdata), .rdata_out(rdata_out), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  logic        exp_stall, exp_req, exp_we, exp_mis, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  int          stall_cnt, req_cnt, err_cnt;
  logic        seen_we;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- spec-level model ----------------
  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'b0001 << (a % 4);
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
      check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
      check("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
      check("rdata_out", rdata_out, exp_rdata);
      if (exp_req) begin
        check("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
        check("bus_addr", bus_addr, exp_addr);
        check("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
        check("bus_wdata", bus_wdata, exp_wdata);
      end
      if (stall)   stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        seen_we = bus_we; seen_addr = bus_addr; seen_be = bus_be; seen_wdata = bus_wdata;
      end
      if (bus_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0; load_unsigned = 1'b0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
  endtask

  task automatic start_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat);
    mem_read = rd; mem_write = wr; mem_size = sz; load_unsigned = uns;
    addr = a; wdata = wd; bus_rdata = rdat; bus_ack = 1'b0;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0;
    exp_mis = m_mis(sz, a); exp_stall = !m_mis(sz, a); exp_req = 1'b0;
  endtask

  task automatic enter_bus(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    exp_req = 1'b1; exp_we = wr; exp_addr = a & ~32'h3;
    exp_be = m_be(sz, a); exp_wdata = m_wd(sz, wd);
  endtask

  // ack_at: the BUS cycle (1-based) in which ack is presented
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_at);
    start_access(rd, wr, sz, uns, a, wd, rdat);
    if (m_mis(sz, a)) begin
      step(); step();
      idle_inputs();
      step();
      return;
    end
    step();
    enter_bus(wr, sz, a, wd);
    for (int i = 1; i <= ack_at; i++) begin
      bus_ack = (i == ack_at);
      step();
    end
    bus_ack = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
    if (!wr) exp_rdata = m_load(sz, uns, a, rdat);
    step();
    idle_inputs();
  endtask

  initial begin
    #100000;
    n_chk++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    idle_inputs();
    bus_rdata = 32'd0; exp_rdata = 32'd0; exp_we = 1'b0;
    exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0;
    seen_we = 1'b0; seen_addr = 32'd0; seen_be = 4'd0; seen_wdata = 32'd0;
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Aligned word load, ack in 3rd BUS cycle
    access(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3);
    check("lw_stall_cycles", stall_cnt, 32'd4);
    check("lw_bus_addr", seen_addr, 32'h10);
    check("lw_bus_be", {28'd0, seen_be}, 32'hF);
    check("lw_rdata", rdata_out, 32'hDEAD_BEEF);
    step();

    // Byte loads at 0x13
    access(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h8000_0000, 1);
    check("lb_stall_cycles", stall_cnt, 32'd2);
    check("lb_bus_be", {28'd0, seen_be}, 32'h8);
    check("lb_rdata", rdata_out, 32'hFFFF_FF80);
    access(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h8000_0000, 2);
    check("lbu_rdata", rdata_out, 32'h0000_0080);

    // Half store at 0x22
    access(0, 1, 2'd1, 0, 32'h22, 32'h1234_ABCD, 32'hFFFF_FFFF, 2);
    check("sh_we", {31'd0, seen_we}, 32'd1);
    check("sh_bus_addr", seen_addr, 32'h20);
    check("sh_bus_be", {28'd0, seen_be}, 32'hC);
    check("sh_bus_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_rdata_kept", rdata_out, 32'h0000_0080);

    // Misaligned accesses: no bus cycle, no stall
    access(1, 0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1);
    check("mis_w_req", req_cnt, 32'd0);
    check("mis_w_stall", stall_cnt, 32'd0);
    access(1, 0, 2'd1, 0, 32'h05, 32'h0, 32'h0, 1);
    check("mis_h_req", req_cnt, 32'd0);
    access(0, 1, 2'd1, 0, 32'h01, 32'hCAFE_F00D, 32'h0, 1);
    check("mis_sh_req", req_cnt, 32'd0);
    access(1, 0, 2'd3, 0, 32'h00, 32'h0, 32'h0, 1);
    check("rsvd_req", req_cnt, 32'd0);

    // Read and write together: the write wins
    access(1, 1, 2'd0, 0, 32'h01, 32'h0000_005A, 32'h1111_1111, 1);
    check("rw_we", {31'd0, seen_we}, 32'd1);
    check("rw_be", {28'd0, seen_be}, 32'h2);
    check("rw_wdata", seen_wdata, 32'h5A5A_5A5A);
    check("rw_rdata_kept", rdata_out, 32'h0000_0080);

    // Half loads and a word load with load_unsigned set
    access(1, 0, 2'd1, 0, 32'h102, 32'h0, 32'h8001_1234, 1);
    check("lh_rdata", rdata_out, 32'hFFFF_8001);
    access(1, 0, 2'd1, 1, 32'h100, 32'h0, 32'h0000_F00D, 2);
    check("lhu_rdata", rdata_out, 32'h0000_F00D);
    access(1, 0, 2'd1, 0, 32'h100, 32'h0, 32'hFFFF_7FFF, 1);
    check("lh_pos_rdata", rdata_out, 32'h0000_7FFF);
    access(1, 0, 2'd2, 1, 32'h104, 32'h0, 32'h8000_0001, 1);
    check("lw_uns_rdata", rdata_out, 32'h8000_0001);
    access(0, 1, 2'd0, 0, 32'h203, 32'h0000_00C3, 32'h0, 1);
    check("sb3_be", {28'd0, seen_be}, 32'h8);

    // Reset in the 2nd BUS cycle, late ack one cycle later
    start_access(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h1122_3344);
    step();
    enter_bus(0, 2'd2, 32'h40, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    exp_rdata = 32'd0;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("rstmid_req", {31'd0, bus_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_rdata", rdata_out, 32'd0);
    check("rstmid_addr", bus_addr, 32'd0);

    // No-ack access: timeout (macro) or unbounded wait (default)
    start_access(1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h55AA_55AA);
    step();
    enter_bus(0, 2'd2, 32'h30, 32'h0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TO; i++) step();
    exp_req = 1'b0; exp_stall = 1'b0; exp_err = 1'b1;
    step();
    idle_inputs();
    step(); step();
    check("to_err_pulses", err_cnt, 32'd1);
    check("to_rdata_kept", rdata_out, 32'd0);
`else
    for (int i = 0; i < 20; i++) step();
    check("noto_stall_held", {31'd0, stall}, 32'd1);
    check("noto_err", err_cnt, 32'd0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
    exp_rdata = 32'h55AA_55AA;
    step();
    idle_inputs();
    check("noto_rdata", rdata_out, 32'h55AA_55AA);
`endif
    step();

    // Stage still works after all of the above
    access(1, 0, 2'd0, 0, 32'h1, 32'h0, 32'h0000_7F00, 1);
    check("final_lb_rdata", rdata_out, 32'h0000_007F);
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
